// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver (LSB first, idle-high line).
//   clk        in   system clock (50 MHz)
//   rst        in   asynchronous reset, active-low
//   baud       in   baud select, latched at start-bit detection
//   rx         in   serial input, asynchronous to clk
//   data_byte  out  last good received byte
//   rx_done    out  one-cycle pulse, data_byte updated
//   rx_busy    out  high while a frame is being received (state != IDLE)
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   parity_err out  one-cycle pulse, even-parity mismatch
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing with a parity
// check; without it the receiver is 8N1 and parity_err is tied to 0.
module uart_rx #(
  parameter int unsigned BPS_DIV0 = 5207,
  parameter int unsigned BPS_DIV1 = 2603,
  parameter int unsigned BPS_DIV2 = 1301,
  parameter int unsigned BPS_DIV3 = 867,
  parameter int unsigned BPS_DIV4 = 433
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] baud,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

  state_t      state, state_nx;
  logic        rx_m, rx_s, rx_s_d;
  logic        fall;
  logic [15:0] div_sel, div_q, cnt;
  logic [16:0] half;
  logic        bit_tick, half_tick;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

  always_comb begin
    case (baud)
      4'd1:    div_sel = 16'(BPS_DIV1);
      4'd2:    div_sel = 16'(BPS_DIV2);
      4'd3:    div_sel = 16'(BPS_DIV3);
      4'd4:    div_sel = 16'(BPS_DIV4);
      default: div_sel = 16'(BPS_DIV0);
    endcase
  end

  // START lasts (DIV+1)/2 clocks so that data bits are sampled mid-bit.
  assign half      = ({1'b0, div_q} + 17'd1) >> 1;
  assign half_tick = (({1'b0, cnt} + 17'd1) == half);
  assign bit_tick  = (cnt == div_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (fall) state_nx = START;
      START:  if (half_tick) state_nx = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (bit_tick && bit_idx == 3'd7) state_nx = PARITY;
      PARITY: if (bit_tick) state_nx = STOP;
`else
      DATA:   if (bit_tick && bit_idx == 3'd7) state_nx = STOP;
`endif
      STOP:   if (bit_tick) state_nx = rx_s ? IDLE : BRK;
      BRK:    if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data_byte <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (fall) div_q <= div_sel;
        end
        START: cnt <= half_tick ? '0 : cnt + 16'd1;
        DATA: begin
          cnt <= bit_tick ? '0 : cnt + 16'd1;
          if (bit_tick) begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: cnt <= bit_tick ? '0 : cnt + 16'd1;
`endif
        STOP: begin
          cnt <= bit_tick ? '0 : cnt + 16'd1;
          if (bit_tick) begin
            if (rx_s) begin
              data_byte <= shift;
              rx_done   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  // Parity result is reported on the stop-sample cycle, alongside rx_done/frame_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (state == PARITY && bit_tick) par_bit <= rx_s;
      if (state == STOP && bit_tick) parity_err <= (^shift) ^ par_bit;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
